// File: rtl/uart_if_pkg.sv
// Register map, frame constants and FSM encodings shared by the frequency report master.
// Pure definitions: no latency, no backpressure.
package uart_if_pkg;
  localparam logic [31:0] ADDR_TX_DATA    = 32'h0000_0000;
  localparam logic [31:0] ADDR_TX_CTRL    = 32'h0000_0001;
  localparam logic [31:0] ADDR_STATUS     = 32'h0000_0003;
  localparam logic [31:0] ADDR_BAUD       = 32'h0000_0004;
  localparam logic [7:0]  FRAME_HDR       = 8'hA5;
  localparam logic [7:0]  TX_START        = 8'h80;
  localparam int          STATUS_BUSY_BIT = 0;
  localparam int          FRAME_BYTES     = 6;

  typedef enum logic [2:0] {
    ST_INIT_BAUD,
    ST_IDLE,
    ST_LOAD,
    ST_WR_DATA,
    ST_WR_CTRL,
    ST_POLL
  } state_t;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ACTIVE,
    BUS_RETRY,
    BUS_RESP
  } bus_state_t;

  function automatic logic [7:0] frame_xor(input logic [31:0] m);
    return m[31:24] ^ m[23:16] ^ m[15:8] ^ m[7:0];
  endfunction
endpackage

// File: rtl/wb_single_master.sv
// One classic Wishbone access per request: strobe the cycle after req, done/fail pulse one cycle after the response.
// Backpressure: req is only taken when idle; rty drops the strobe for one cycle and reissues; silence aborts after ACK_TIMEOUT cycles.
module wb_single_master
  import uart_if_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_dat,
  output logic        done,
  output logic        fail,
  output logic [31:0] rd_dat,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [7:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdat,
  input  logic [31:0] bus_rdat,
  input  logic        ack,
  input  logic        err,
  input  logic        rty
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  bus_state_t    state, state_next;
  logic          we_q;
  logic          resp_ok;
  logic [TW-1:0] tmo;
  logic          timed_out;

  assign timed_out = (tmo == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    state_next = state;
    case (state)
      BUS_IDLE:   if (req) state_next = BUS_ACTIVE;
      BUS_ACTIVE: begin
        if (ack || err)     state_next = BUS_RESP;
        else if (rty)       state_next = BUS_RETRY;
        else if (timed_out) state_next = BUS_RESP;
      end
      BUS_RETRY:  state_next = BUS_ACTIVE;
      default:    state_next = BUS_IDLE;
    endcase
  end

  // Address/data stay latched across a retry so the reissued access is identical.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BUS_IDLE;
      we_q     <= 1'b0;
      bus_addr <= '0;
      bus_wdat <= '0;
      tmo      <= '0;
      resp_ok  <= 1'b0;
      rd_dat   <= '0;
    end else begin
      state <= state_next;
      if (state == BUS_IDLE && req) begin
        we_q     <= req_we;
        bus_addr <= req_addr;
        bus_wdat <= req_dat;
      end
      if (state != BUS_ACTIVE) tmo <= '0;
      else                     tmo <= tmo + 1'b1;
      if (state == BUS_ACTIVE) begin
        resp_ok <= ack;
        if (ack) rd_dat <= bus_rdat;
      end
    end
  end

  assign bus_stb = (state == BUS_ACTIVE);
  assign bus_cyc = bus_stb;
  assign bus_we  = bus_stb & we_q;
  assign bus_sel = bus_stb ? 8'h01 : 8'h00;
  assign done    = (state == BUS_RESP) &&  resp_ok;
  assign fail    = (state == BUS_RESP) && !resp_ok;
endmodule

// File: rtl/freq_report_master.sv
// Serialises each measurement into a 6-byte UART frame (A5, 4 payload bytes MSB first, XOR) after a one-time baud setup.
// First strobe two cycles after meas_valid_i in idle; one-deep holding register, overwrite flagged by overrun_o.
module freq_report_master
  import uart_if_pkg::*;
#(
  parameter logic [31:0] BAUD_DIV    = 32'd32766,
  parameter int          ACK_TIMEOUT = 64,
  parameter int          POLL_LIMIT  = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        meas_valid_i,
  input  logic [31:0] meas_data_i,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        err_flag_o,
  output logic [31:0] addr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic [7:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i,
  output logic        lock_o,
  output logic        tagn_o
);
  state_t      state, state_next;
  logic        hold_full;
  logic [31:0] hold;
  logic [47:0] frame;
  logic [2:0]  byte_idx;
  logic [31:0] poll_cnt;
  logic        req, req_we;
  logic [31:0] req_addr, req_dat;
  logic        done, fail, abort;
  logic [31:0] rd_dat;
  logic        tx_busy, last_byte, poll_exhausted;
  logic        busy_q, overrun_q, err_q;

  assign tx_busy        = (rd_dat & (32'h1 << STATUS_BUSY_BIT)) != 32'h0;
  assign last_byte      = (byte_idx == 3'(FRAME_BYTES - 1));
  assign poll_exhausted = (poll_cnt == 32'(POLL_LIMIT - 1));

  // LOAD already issues the header write so the first strobe lands one cycle after LOAD.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    req_we     = 1'b1;
    req_addr   = ADDR_TX_DATA;
    req_dat    = '0;
    abort      = 1'b0;
    case (state)
      ST_INIT_BAUD: begin
        req      = 1'b1;
        req_addr = ADDR_BAUD;
        req_dat  = BAUD_DIV;
        if (done) state_next = ST_IDLE;
      end
      ST_IDLE: if (hold_full) state_next = ST_LOAD;
      ST_LOAD: begin
        req        = 1'b1;
        req_dat    = {24'h0, FRAME_HDR};
        state_next = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        req     = 1'b1;
        req_dat = {24'h0, frame[47:40]};
        if (done) state_next = ST_WR_CTRL;
      end
      ST_WR_CTRL: begin
        req      = 1'b1;
        req_addr = ADDR_TX_CTRL;
        req_dat  = {24'h0, TX_START};
        if (done) state_next = ST_POLL;
      end
      ST_POLL: begin
        req      = 1'b1;
        req_we   = 1'b0;
        req_addr = ADDR_STATUS;
        if (done && !tx_busy)           state_next = last_byte ? ST_IDLE : ST_WR_DATA;
        else if (done && poll_exhausted) abort = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
    if (fail)  abort      = 1'b1;
    if (abort) state_next = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_INIT_BAUD;
      hold_full <= 1'b0;
      hold      <= '0;
      frame     <= '0;
      byte_idx  <= '0;
      poll_cnt  <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      busy_q    <= (state_next != ST_IDLE);
      overrun_q <= meas_valid_i && hold_full && (state != ST_LOAD);
      if (meas_valid_i)          begin hold <= meas_data_i; hold_full <= 1'b1; end
      else if (state == ST_LOAD) hold_full <= 1'b0;
      if (state == ST_LOAD) begin
        frame    <= {FRAME_HDR, hold, frame_xor(hold)};
        byte_idx <= '0;
      end else if (state == ST_POLL && state_next == ST_WR_DATA) begin
        frame    <= {frame[39:0], 8'h00};
        byte_idx <= byte_idx + 3'd1;
      end
      if (state == ST_WR_CTRL)        poll_cnt <= '0;
      else if (state == ST_POLL && done) poll_cnt <= poll_cnt + 32'd1;
      if (abort) err_q <= 1'b1;
    end
  end

  wb_single_master #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_bus (
    .clk      (clk_i),
    .rst      (rst_i),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_dat  (req_dat),
    .done     (done),
    .fail     (fail),
    .rd_dat   (rd_dat),
    .bus_cyc  (cyc_o),
    .bus_stb  (stb_o),
    .bus_we   (we_o),
    .bus_sel  (sel_o),
    .bus_addr (addr_o),
    .bus_wdat (dat_o),
    .bus_rdat (dat_i),
    .ack      (ack_i),
    .err      (err_i),
    .rty      (rty_i)
  );

  assign busy_o     = busy_q;
  assign overrun_o  = overrun_q;
  assign err_flag_o = err_q;
  assign lock_o     = 1'b0;
  assign tagn_o     = 1'b0;
endmodule

// File: tb/tb_freq_report_master.sv
// Bench: a Wishbone slave model plus an expected-access queue built from frame rules, checked on every strobe cycle.
module tb_freq_report_master;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        meas_valid = 1'b0;
  logic [31:0] meas_data = 32'h0;
  logic        busy, overrun, err_flag, we, cyc, stb, lock, tagn;
  logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic [31:0] addr, dat_o;
  logic [31:0] dat_i = 32'h0;
  logic [7:0]  sel;

  int   checks = 0, passed = 0;
  acc_t exp_q[$];
  acc_t frm_q[$];
  logic [7:0] wr_log[$];
  int   acc_idx = 0, cur_idx = 0, err_at = -1, rty_at = -1, busy_reads = 0;
  int   rd_cnt = 0, ovr_cnt = 0, run_len = 0, last_len = 0;
  bit   silent = 1'b0, no_check = 1'b0, prev_stb = 1'b0;
  acc_t start_acc = '0;

  always #5 clk = ~clk;

  freq_report_master dut (
    .clk_i(clk), .rst_i(rst), .meas_valid_i(meas_valid), .meas_data_i(meas_data),
    .busy_o(busy), .overrun_o(overrun), .err_flag_o(err_flag),
    .addr_o(addr), .dat_o(dat_o), .dat_i(dat_i), .we_o(we), .sel_o(sel),
    .cyc_o(cyc), .stb_o(stb), .ack_i(ack), .err_i(err), .rty_i(rty),
    .lock_o(lock), .tagn_o(tagn)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic acc_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
    return {w, a, d};
  endfunction

  // Expected bus accesses for one frame: per byte a data write, a start write, then status reads.
  task automatic build_frame(input logic [31:0] m, input int extra_polls);
    logic [7:0] b [6];
    frm_q.delete();
    b[0] = 8'hA5;
    b[1] = m[31:24];
    b[2] = m[23:16];
    b[3] = m[15:8];
    b[4] = m[7:0];
    b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
    for (int i = 0; i < 6; i++) begin
      frm_q.push_back(mk(1'b1, 32'h0, {24'h0, b[i]}));
      frm_q.push_back(mk(1'b1, 32'h1, 32'h80));
      for (int p = 0; p <= ((i == 0) ? extra_polls : 0); p++)
        frm_q.push_back(mk(1'b0, 32'h3, 32'h0));
    end
  endtask

  task automatic flush();
    foreach (frm_q[i]) exp_q.push_back(frm_q[i]);
  endtask

  task automatic pulse(input logic [31:0] d);
    @(negedge clk);
    meas_valid = 1'b1;
    meas_data  = d;
    @(negedge clk);
    meas_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy || stb) && n < budget);
    check(name, 80'({exp_q.size() == 0, busy}), 80'(2'b10));
    exp_q.delete();
  endtask

  // Slave model and per-strobe compare against the expected-access queue.
  always @(negedge clk) begin
    ack   = 1'b0;
    err   = 1'b0;
    rty   = 1'b0;
    dat_i = 32'h0;
    if (overrun) ovr_cnt++;
    if (stb) begin
      if (!prev_stb) begin
        cur_idx   = acc_idx;
        acc_idx++;
        run_len   = 0;
        start_acc = mk(we, addr, dat_o);
        if (!we && addr == 32'h3) rd_cnt++;
        if (we && addr == 32'h0)  wr_log.push_back(dat_o[7:0]);
        if (!no_check) begin
          check("access_pending", 80'(exp_q.size() > 0), 80'(1));
          if (exp_q.size() > 0) check("access", 80'(start_acc), 80'(exp_q.pop_front()));
        end
      end
      run_len++;
      check("strobe_attrs", 80'({sel, lock, tagn, cyc, we, addr, dat_o}),
            80'({8'h01, 1'b0, 1'b0, 1'b1, start_acc}));
      if (!silent) begin
        if (cur_idx == err_at)      err = 1'b1;
        else if (cur_idx == rty_at) rty = 1'b1;
        else begin
          ack = 1'b1;
          if (!we && addr == 32'h3) begin
            dat_i = {31'h0, busy_reads > 0};
            if (busy_reads > 0) busy_reads--;
          end
        end
      end
    end else if (prev_stb) begin
      last_len = run_len;
    end
    prev_stb = stb;
  end

  initial begin
    int o0;
    int n;
    logic [7:0] lit [6];
    lit = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};

    exp_q.push_back(mk(1'b1, 32'h4, 32'd32766));
    repeat (3) @(negedge clk);
    check("reset_ctrl", 80'({cyc, stb, we, busy, overrun, err_flag, sel}), 80'(0));
    check("reset_addr_dat", 80'({addr, dat_o}), 80'(0));
    rst = 1'b0;
    @(negedge clk);
    check("init_first_strobe", 80'({stb, busy}), 80'(2'b11));
    wait_quiet("init_done", 100);
    check("init_err_flag", 80'(err_flag), 80'(0));

    wr_log.delete();
    rd_cnt = 0;
    build_frame(32'h12345678, 0);
    flush();
    pulse(32'h12345678);
    check("lat_edge_n", 80'({busy, stb}), 80'(2'b00));
    @(negedge clk);
    check("lat_load", 80'({busy, stb}), 80'(2'b10));
    @(negedge clk);
    check("lat_first_strobe", 80'({busy, stb}), 80'(2'b11));
    wait_quiet("frame_12345678", 200);
    check("frame_byte_count", 80'(wr_log.size()), 80'(6));
    for (int i = 0; i < 6; i++)
      check($sformatf("frame_byte%0d", i),
            80'((i < wr_log.size()) ? {1'b0, wr_log[i]} : 9'h100), 80'({1'b0, lit[i]}));
    check("status_reads_plain", 80'(rd_cnt), 80'(6));

    rd_cnt = 0;
    busy_reads = 10;
    build_frame(32'hDEADBEEF, 10);
    flush();
    pulse(32'hDEADBEEF);
    wait_quiet("frame_busy_polls", 250);
    check("status_reads_busy", 80'(rd_cnt), 80'(16));

    o0 = ovr_cnt;
    build_frame(32'hA0A0A0A0, 0);
    flush();
    build_frame(32'h00000002, 0);
    flush();
    pulse(32'hA0A0A0A0);
    repeat (10) @(negedge clk);
    pulse(32'h00000001);
    repeat (10) @(negedge clk);
    pulse(32'h00000002);
    wait_quiet("overrun_frames", 400);
    check("overrun_pulses", 80'(ovr_cnt - o0), 80'(1));

    o0 = ovr_cnt;
    build_frame(32'h11223344, 0);
    flush();
    build_frame(32'h55667788, 0);
    flush();
    @(negedge clk); meas_valid = 1'b1; meas_data = 32'h11223344;
    @(negedge clk); meas_valid = 1'b0;
    @(negedge clk); meas_valid = 1'b1; meas_data = 32'h55667788;
    @(negedge clk); meas_valid = 1'b0;
    wait_quiet("load_same_cycle_frames", 400);
    check("load_same_cycle_no_overrun", 80'(ovr_cnt - o0), 80'(0));

    build_frame(32'hCAFEF00D, 0);
    frm_q.insert(4, frm_q[4]);
    rty_at = acc_idx + 4;
    flush();
    pulse(32'hCAFEF00D);
    wait_quiet("retry_frame", 250);
    rty_at = -1;
    check("retry_no_err", 80'(err_flag), 80'(0));

    build_frame(32'h87654321, 0);
    frm_q = frm_q[0:6];
    err_at = acc_idx + 6;
    flush();
    pulse(32'h87654321);
    wait_quiet("err_abort", 200);
    err_at = -1;
    check("err_flag_set", 80'(err_flag), 80'(1));

    no_check = 1'b1;
    pulse(32'h55AA55AA);
    repeat (12) @(negedge clk);
    n = 0;
    while (!stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_hits_strobe", 80'(stb), 80'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rst_bus_released", 80'({cyc, stb, busy, err_flag}), 80'(0));
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 32'h4, 32'd32766));
    no_check = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_rewrite_strobe", 80'(stb), 80'(1));
    wait_quiet("rst_baud_rewrite", 100);

    silent = 1'b1;
    build_frame(32'h0F0F0F0F, 0);
    frm_q = frm_q[0:0];
    flush();
    pulse(32'h0F0F0F0F);
    wait_quiet("timeout_abort", 300);
    check("timeout_strobe_len", 80'(last_len), 80'(64));
    check("timeout_err_flag", 80'(err_flag), 80'(1));
    silent = 1'b0;

    repeat (20) @(negedge clk);
    check("no_stray_access", 80'(exp_q.size()), 80'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/freq_report_master.md
# freq_report_master

Wishbone master that serialises each 32-bit frequency measurement into a 6-byte report frame and pushes it out through `uart_interface`, one byte per TX transaction sequence. Sits between the frequency-counter measurement core (upstream, `meas_valid_i`/`meas_data_i`) and the `uart_interface` Wishbone slave (downstream). On reset exit it also programs the UART baud divider once.

## Interface
Parameters:
- `BAUD_DIV`, 32766: value written to the baud divider register at init.
- `ACK_TIMEOUT`, 64: cycles a strobe may wait for `ack_i`/`err_i`/`rty_i` before abort.
- `POLL_LIMIT`, 65535: status reads allowed per byte before abort.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  synchronous active-high reset.
- `meas_valid_i`  in  1  one-cycle pulse: new measurement.
- `meas_data_i`  in  32  measurement value.
- `busy_o`  out  1  frame or init in progress.
- `overrun_o`  out  1  one-cycle pulse: holding register overwritten.
- `err_flag_o`  out  1  sticky: frame aborted (err/timeout/poll limit); cleared by reset only.
- `addr_o`  out  32  Wishbone address.
- `dat_o`  out  32  write data (byte in [7:0], upper bits 0).
- `dat_i`  in  32  read data.
- `we_o`  out  1  write enable.
- `sel_o`  out  8  byte select; 8'h01 for every access.
- `cyc_o`, `stb_o`  out  1  cycle / strobe.
- `ack_i`, `err_i`, `rty_i`  in  1  slave responses.
- `lock_o`, `tagn_o`  out  1  tied 0.

## Operation
- Slave map: 0x00 TX data, 0x01 TX control (write 8'h80 = start), 0x03 status (bit0 = tx_busy), 0x04 baud divider.
- Frame: 8'hA5, meas[31:24], meas[23:16], meas[15:8], meas[7:0], XOR of the four payload bytes.
- FSM: INIT_BAUD -> IDLE -> LOAD -> WR_DATA -> WR_CTRL -> POLL -> (next byte: WR_DATA | last: IDLE); any abort -> IDLE with `err_flag_o` set.
- INIT_BAUD: write `BAUD_DIV` to 0x04 after reset; measurements arriving meanwhile are held.
- LOAD: copy holding register into frame shift register, byte index = 0, compute checksum.
- WR_DATA: write frame byte to 0x00. WR_CTRL: write 8'h80 to 0x01. POLL: read 0x03 repeatedly until bit0 = 0, then advance.
- Holding register one deep: `meas_valid_i` while holding is full overwrites it and pulses `overrun_o`. In IDLE with holding full, go to LOAD next cycle.
- `rty_i`: drop strobe, reissue identical access after one idle cycle, unlimited. `err_i`, ack timeout, or poll limit: abort rest of frame; held measurement, if any, is still sent.
- `busy_o` = state != IDLE.

## Timing
- Reset values: `cyc_o`, `stb_o`, `we_o`, `busy_o` (until next cycle), `overrun_o`, `err_flag_o` = 0; `addr_o`, `dat_o`, `sel_o` = 0; holding empty; state = INIT_BAUD.
- Classic single access: `cyc_o`/`stb_o`/addr/data/`we_o` asserted together, held stable until a response cycle; deasserted the cycle after; at least one idle cycle between accesses.
- `ack_i` is sampled only while `stb_o` = 1; responses outside a strobe are ignored.
- Latency: `meas_valid_i` in IDLE at edge N -> LOAD at N+1 -> first `stb_o` at N+2.
- Same-cycle `meas_valid_i` and LOAD consumption: old value is consumed, new value fills holding, no overrun.
- Timeout counter resets on each new strobe; abort on cycle `ACK_TIMEOUT` with no response.
- `rst_i` mid-frame: bus released the following cycle, frame discarded, init rewrites baud divider.

## Structure
- Package `uart_if_pkg`: register addresses, 8'hA5 header, 8'h80 TX start, status bit index, FSM state enum.
- Sub-module `wb_single_master`: one-access engine (request/ack, retry, timeout, read data capture); FSM sits above it.

## Test plan
- Reset then ack-every-access slave -> first access is write 0x04 data 32766, `busy_o` falls after ack.
- `meas_data_i` = 32'h12345678 -> writes to 0x00 in order A5, 12, 34, 56, 78, 08, each followed by 0x01 <- 80 and status poll.
- Status bit0 held 1 for 10 reads -> 10 extra reads, no data write until cleared.
- Two measurements during a frame (0x1, then 0x2) -> `overrun_o` pulse once, next frame carries 0x00000002.
- `err_i` on third byte's data write -> `err_flag_o` = 1, remaining bytes skipped, IDLE; `rty_i` once -> same access reissued, frame completes.
- Slave silent -> abort after 64 cycles of strobe; `rst_i` mid-frame -> `cyc_o` low next cycle, baud rewrite follows.
